// File: rtl/uart_packet_rx.sv
// uart_packet_rx: framed-packet parser behind the UART receiver.
// Hunts for SYNC_BYTE, reads LEN, assembles little-endian 16-bit words into
// a show-ahead FIFO and reports each framed packet's outcome on a status pulse.
// Optional feature macro: UART_PACKET_CSUM_EN adds the trailing XOR checksum
// byte and status 2 (checksum mismatch); without it the frame ends after the
// last payload byte.
//
// state  | meaning
// IDLE   | hunting for SYNC_BYTE, other bytes ignored
// LEN    | next byte is the word count
// LO     | next byte is the low byte of a word
// HI     | next byte is the high byte; the word is pushed
// CSUM   | next byte is the checksum (only reachable with the checksum enabled)
module uart_packet_rx #(
   parameter int         FIFO_DEPTH     = 8,
   parameter int         TIMEOUT_CYCLES = 4096,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic [7:0]  data_in,
   input  logic        ready_in,
   output logic        valid_out,
   output logic [15:0] data_out,
   output logic        last_out,
   output logic        status_valid_out,
   output logic [2:0]  status_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FULL_CNT = FW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] ST_OK   = 3'd0;
   localparam logic [2:0] ST_ZERO = 3'd1;
   localparam logic [2:0] ST_BAD  = 3'd2;
   localparam logic [2:0] ST_TMO  = 3'd3;
   localparam logic [2:0] ST_OVF  = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_LO, S_HI, S_CSUM} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      lo_q, lo_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            stat_v_q, stat_v_d;
   logic [2:0]      stat_q, stat_d;
`ifdef UART_PACKET_CSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic [16:0]     fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic            push, push_last, pop, fifo_full;

   assign fifo_full = (fill_q == FULL_CNT);
   assign pop       = valid_out && ready_in;

   // Packet FSM next-state, word push request, timeout and status decisions.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      tmo_d     = tmo_q;
      stat_v_d  = 1'b0;
      stat_d    = stat_q;
      push      = 1'b0;
      push_last = 1'b0;
`ifdef UART_PACKET_CSUM_EN
      csum_d    = csum_q;
`endif
      if (state_q == S_IDLE) begin
         tmo_d = '0;
         if (valid_in && (data_in == SYNC_BYTE)) begin
            state_d = S_LEN;
         end
      end else if (valid_in) begin
         tmo_d = '0;
         case (state_q)
            S_LEN: begin
               if (data_in == 8'd0) begin
                  stat_v_d = 1'b1;
                  stat_d   = ST_ZERO;
                  state_d  = S_IDLE;
               end else begin
                  cnt_d   = data_in;
`ifdef UART_PACKET_CSUM_EN
                  csum_d  = data_in;
`endif
                  state_d = S_LO;
               end
            end
            S_LO: begin
               lo_d    = data_in;
`ifdef UART_PACKET_CSUM_EN
               csum_d  = csum_q ^ data_in;
`endif
               state_d = S_HI;
            end
            S_HI: begin
               // A full FIFO still takes the word if the head leaves this cycle.
               if (fifo_full && !pop) begin
                  stat_v_d = 1'b1;
                  stat_d   = ST_OVF;
                  state_d  = S_IDLE;
               end else begin
                  push   = 1'b1;
                  cnt_d  = cnt_q - 8'd1;
`ifdef UART_PACKET_CSUM_EN
                  csum_d = csum_q ^ data_in;
`endif
                  if (cnt_q == 8'd1) begin
                     push_last = 1'b1;
`ifdef UART_PACKET_CSUM_EN
                     state_d   = S_CSUM;
`else
                     stat_v_d  = 1'b1;
                     stat_d    = ST_OK;
                     state_d   = S_IDLE;
`endif
                  end else begin
                     state_d = S_LO;
                  end
               end
            end
            S_CSUM: begin
`ifdef UART_PACKET_CSUM_EN
               stat_v_d = 1'b1;
               stat_d   = (data_in == csum_q) ? ST_OK : ST_BAD;
`endif
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (tmo_q == TMO_LAST) begin
         tmo_d    = '0;
         stat_v_d = 1'b1;
         stat_d   = ST_TMO;
         state_d  = S_IDLE;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   // FSM, datapath and status registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         lo_q     <= '0;
         tmo_q    <= '0;
         stat_v_q <= 1'b0;
         stat_q   <= '0;
`ifdef UART_PACKET_CSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         tmo_q    <= tmo_d;
         stat_v_q <= stat_v_d;
         stat_q   <= stat_d;
`ifdef UART_PACKET_CSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   // FIFO pointer and occupancy next values.
   always_comb begin
      wr_d = push ? wr_q + PW'(1) : wr_q;
      rd_d = pop ? rd_q + PW'(1) : rd_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + FW'(1);
         2'b01:   fill_d = fill_q - FW'(1);
         default: fill_d = fill_q;
      endcase
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fill_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fill_q <= fill_d;
      end
   end

   // FIFO storage: {last, hi, lo}; contents only matter while occupied.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem_q[wr_q] <= {push_last, data_in, lo_q};
      end
   end

   assign valid_out           = (fill_q != '0);
   assign {last_out, data_out} = valid_out ? fifo_mem_q[rd_q] : 17'd0;
   assign status_valid_out    = stat_v_q;
   assign status_out          = stat_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx. Frames are built from the framing
// rules (sync, length, little-endian payload, optional XOR checksum) and the
// expected word stream and status codes are derived from them.
module tb_uart_packet_rx;

   localparam int         DEPTH = 8;
   localparam int         TMO   = 64;
   localparam logic [7:0] SYNC  = 8'hA5;
`ifdef UART_PACKET_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in, valid_in, ready_in;
   logic [7:0]  data_in;
   logic        valid_out, last_out, status_valid_out;
   logic [15:0] data_out;
   logic [2:0]  status_out;

   uart_packet_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
      .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
      .last_out(last_out), .status_valid_out(status_valid_out), .status_out(status_out)
   );

   always #5 clk_in = ~clk_in;

   int          vectors = 0;
   int          miscompares = 0;
   logic [16:0] obs_w[$], exp_w[$];
   logic [2:0]  obs_s[$], exp_s[$];
   bit          rand_ready = 1'b0;

   // Observe accepted words and status pulses away from the active edge.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (valid_out && ready_in) obs_w.push_back({last_out, data_out});
         if (status_valid_out) obs_s.push_back(status_out);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
      if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      valid_in = 1'b1;
      data_in  = b;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic flush();
      obs_w.delete(); exp_w.delete(); obs_s.delete(); exp_s.delete();
   endtask

   task automatic wait_quiet(input int n);
      for (int i = 0; i < n; i++) begin
         if (obs_w.size() >= exp_w.size() && obs_s.size() >= exp_s.size()) break;
         tick();
      end
      idle(6);
   endtask

   // Reference model: send one frame and record what it must produce.
   // cut < 0 sends the whole frame; otherwise only cut bytes after LEN are sent
   // and the frame is left to time out. csum_mode: -1 correct, -2 corrupted,
   // >= 0 explicit checksum byte.
   task automatic send_packet(input logic [7:0] len, input int cut, input int csum_mode,
                              input int gap_max, input logic [7:0] pay[$]);
      logic [7:0] frame[$];
      logic [7:0] cs;
      int         l, n_send;
      l = int'(len);
      send_byte(SYNC);
      idle($urandom_range(0, gap_max));
      send_byte(len);
      if (l == 0) begin
         exp_s.push_back(3'd1);
      end else begin
         cs = len;
         for (int i = 0; i < 2 * l; i++) begin
            cs ^= pay[i];
            frame.push_back(pay[i]);
         end
         if (CSUM_ON) begin
            if (csum_mode == -1)      frame.push_back(cs);
            else if (csum_mode == -2) frame.push_back(cs ^ 8'($urandom_range(1, 255)));
            else                      frame.push_back(8'(csum_mode));
         end
         n_send = (cut < 0) ? frame.size() : cut;
         for (int i = 0; i < n_send; i++) begin
            idle($urandom_range(0, gap_max));
            send_byte(frame[i]);
         end
         for (int w = 0; w < l; w++) begin
            if (2 * w + 1 < n_send) exp_w.push_back({(w == l - 1), pay[2 * w + 1], pay[2 * w]});
         end
         if (cut >= 0) begin
            exp_s.push_back(3'd3);
            idle(TMO + 3);
         end else if (CSUM_ON) begin
            exp_s.push_back((frame[2 * l] == cs) ? 3'd0 : 3'd2);
         end else begin
            exp_s.push_back(3'd0);
         end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1; valid_in = 1'b0; data_in = 8'h00; ready_in = 1'b1;
      #12;
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
      vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL reset data_out: got %h want 0000", data_out); end
      vectors++; if (last_out !== 1'b0) begin miscompares++; $display("FAIL reset last_out: got %b want 0", last_out); end
      vectors++; if (status_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset status_valid_out: got %b want 0", status_valid_out); end
      vectors++; if (status_out !== 3'd0) begin miscompares++; $display("FAIL reset status_out: got %0d want 0", status_out); end
      tick();
      rst_in = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      logic [7:0] pl[$];
      ready_in = 1'b1;
      pl.delete(); pl.push_back(8'h34); pl.push_back(8'h12); pl.push_back(8'h78); pl.push_back(8'h56);
      send_packet(8'd2, -1, -1, 0, pl);
      // second frame immediately behind the first: back-to-back bytes
      pl.delete(); pl.push_back(8'hEF); pl.push_back(8'hBE); pl.push_back(8'hAD); pl.push_back(8'hDE);
      pl.push_back(8'h01); pl.push_back(8'h00);
      send_packet(8'd3, -1, -1, 0, pl);
      wait_quiet(200);
      vectors++;
      if (obs_w.size() !== exp_w.size() || obs_s.size() !== exp_s.size()) begin
         miscompares++;
         $display("FAIL basic counts: got %0d words/%0d status, want %0d/%0d", obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL basic word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      foreach (exp_s[i]) if (i < obs_s.size()) begin
         vectors++;
         if (obs_s[i] !== exp_s[i]) begin miscompares++; $display("FAIL basic status%0d: got %0d want %0d", i, obs_s[i], exp_s[i]); end
      end
      flush();
   endtask

   task automatic test_bad_csum();
      logic [7:0] pl[$];
      ready_in = 1'b1;
      pl.delete(); pl.push_back(8'h34); pl.push_back(8'h12); pl.push_back(8'h78); pl.push_back(8'h56);
      send_packet(8'd2, -1, 0, 0, pl);
      wait_quiet(200);
      vectors++;
      if (obs_w.size() !== exp_w.size() || obs_s.size() !== exp_s.size()) begin
         miscompares++;
         $display("FAIL bad_csum counts: got %0d words/%0d status, want %0d/%0d", obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL bad_csum word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      foreach (exp_s[i]) if (i < obs_s.size()) begin
         vectors++;
         if (obs_s[i] !== exp_s[i]) begin miscompares++; $display("FAIL bad_csum status%0d: got %0d want %0d", i, obs_s[i], exp_s[i]); end
      end
      flush();
   endtask

   task automatic test_zero_len_noise();
      logic [7:0] pl[$];
      ready_in = 1'b1;
      pl.delete();
      send_packet(8'd0, -1, -1, 0, pl);
      pl.push_back(8'hCD); pl.push_back(8'hAB);
      send_packet(8'd1, -1, -1, 0, pl);
      idle(2);
      send_byte(8'h11);
      send_byte(8'h22);
      pl.delete(); pl.push_back(8'h99); pl.push_back(8'h88);
      send_packet(8'd1, -1, -1, 2, pl);
      wait_quiet(200);
      vectors++;
      if (obs_w.size() !== exp_w.size() || obs_s.size() !== exp_s.size()) begin
         miscompares++;
         $display("FAIL zero_noise counts: got %0d words/%0d status, want %0d/%0d", obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL zero_noise word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      foreach (exp_s[i]) if (i < obs_s.size()) begin
         vectors++;
         if (obs_s[i] !== exp_s[i]) begin miscompares++; $display("FAIL zero_noise status%0d: got %0d want %0d", i, obs_s[i], exp_s[i]); end
      end
      flush();
   endtask

   task automatic test_timeout();
      int         first, pulses;
      logic [2:0] seen;
      ready_in = 1'b1;
      first = -1; pulses = 0; seen = 3'd0;
      send_byte(SYNC); send_byte(8'd3); send_byte(8'h01); send_byte(8'h02);
      exp_w.push_back({1'b0, 8'h02, 8'h01});
      exp_s.push_back(3'd3);
      for (int k = 1; k <= TMO + 4; k++) begin
         tick();
         if (status_valid_out) begin
            if (first < 0) begin first = k; seen = status_out; end
            pulses++;
         end
      end
      vectors++; if (first !== TMO) begin miscompares++; $display("FAIL timeout delay: got %0d cycles want %0d", first, TMO); end
      vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL timeout pulse width: got %0d cycles want 1", pulses); end
      vectors++; if (seen !== 3'd3) begin miscompares++; $display("FAIL timeout code: got %0d want 3", seen); end
      wait_quiet(50);
      vectors++;
      if (obs_w.size() !== exp_w.size() || obs_s.size() !== exp_s.size()) begin
         miscompares++;
         $display("FAIL timeout counts: got %0d words/%0d status, want %0d/%0d", obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL timeout word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      flush();
   endtask

   task automatic test_overflow();
      logic [7:0] pl[$];
      logic [7:0] cs;
      ready_in = 1'b0;
      cs = 8'd9;
      for (int i = 0; i < 18; i++) begin
         pl.push_back(8'(i + 1));
         cs ^= 8'(i + 1);
      end
      send_byte(SYNC);
      send_byte(8'd9);
      foreach (pl[i]) send_byte(pl[i]);
      if (CSUM_ON) send_byte(cs);
      idle(4);
      exp_s.push_back(3'd4);
      vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL overflow held valid_out: got %b want 1", valid_out); end
      vectors++;
      if (obs_s.size() !== 1 || obs_w.size() !== 0) begin
         miscompares++;
         $display("FAIL overflow pre-drain: got %0d status/%0d words want 1/0", obs_s.size(), obs_w.size());
      end else begin
         vectors++;
         if (obs_s[0] !== 3'd4) begin miscompares++; $display("FAIL overflow code: got %0d want 4", obs_s[0]); end
      end
      for (int w = 0; w < DEPTH; w++) exp_w.push_back({1'b0, pl[2 * w + 1], pl[2 * w]});
      ready_in = 1'b1;
      wait_quiet(100);
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL overflow drained valid_out: got %b want 0", valid_out); end
      vectors++;
      if (obs_w.size() !== exp_w.size()) begin
         miscompares++;
         $display("FAIL overflow drain count: got %0d words want %0d", obs_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL overflow word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      flush();
   endtask

   task automatic test_reset_mid();
      logic [7:0] pl[$];
      ready_in = 1'b0;
      send_byte(SYNC); send_byte(8'd4);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
      vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL midreset pre valid_out: got %b want 1", valid_out); end
      #2 rst_in = 1'b1;
      #1;
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL midreset valid_out: got %b want 0", valid_out); end
      vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL midreset data_out: got %h want 0000", data_out); end
      vectors++; if (last_out !== 1'b0) begin miscompares++; $display("FAIL midreset last_out: got %b want 0", last_out); end
      vectors++; if (status_valid_out !== 1'b0) begin miscompares++; $display("FAIL midreset status_valid_out: got %b want 0", status_valid_out); end
      vectors++; if (status_out !== 3'd0) begin miscompares++; $display("FAIL midreset status_out: got %0d want 0", status_out); end
      idle(2);
      rst_in   = 1'b0;
      ready_in = 1'b1;
      idle(2);
      pl.delete(); pl.push_back(8'hEF); pl.push_back(8'hBE);
      send_packet(8'd1, -1, -1, 0, pl);
      wait_quiet(200);
      vectors++;
      if (obs_w.size() !== exp_w.size() || obs_s.size() !== exp_s.size()) begin
         miscompares++;
         $display("FAIL midreset counts: got %0d words/%0d status, want %0d/%0d", obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL midreset word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      foreach (exp_s[i]) if (i < obs_s.size()) begin
         vectors++;
         if (obs_s[i] !== exp_s[i]) begin miscompares++; $display("FAIL midreset status%0d: got %0d want %0d", i, obs_s[i], exp_s[i]); end
      end
      flush();
   endtask

   task automatic test_random();
      logic [7:0] pl[$];
      logic [7:0] len, nb;
      int         kind, l;
      rand_ready = 1'b1;
      for (int p = 0; p < 30; p++) begin
         for (int i = 0; i < 100 && valid_out; i++) tick();
         kind = $urandom_range(0, 9);
         len  = 8'($urandom_range(1, 4));
         l    = int'(len);
         pl.delete();
         for (int i = 0; i < 2 * l; i++) pl.push_back(8'($urandom));
         if (kind == 3) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) begin
               nb = 8'($urandom);
               if (nb == SYNC) nb = 8'h11;
               send_byte(nb);
            end
         end
         case (kind)
            0:       send_packet(8'd0, -1, -1, 3, pl);
            1:       send_packet(len, $urandom_range(0, 2 * l - 1 + int'(CSUM_ON)), -1, 3, pl);
            2:       send_packet(len, -1, -2, 3, pl);
            default: send_packet(len, -1, -1, 3, pl);
         endcase
         idle($urandom_range(0, 3));
      end
      wait_quiet(2000);
      rand_ready = 1'b0;
      ready_in   = 1'b1;
      vectors++;
      if (obs_w.size() !== exp_w.size() || obs_s.size() !== exp_s.size()) begin
         miscompares++;
         $display("FAIL random counts: got %0d words/%0d status, want %0d/%0d", obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
      end
      foreach (exp_w[i]) if (i < obs_w.size()) begin
         vectors++;
         if (obs_w[i] !== exp_w[i]) begin miscompares++; $display("FAIL random word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
      end
      foreach (exp_s[i]) if (i < obs_s.size()) begin
         vectors++;
         if (obs_s[i] !== exp_s[i]) begin miscompares++; $display("FAIL random status%0d: got %0d want %0d", i, obs_s[i], exp_s[i]); end
      end
      flush();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_csum();
      test_zero_len_noise();
      test_timeout();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
